data_mem_access: RTL and testbench

DATA_MEM_ACCESS -- requirements
Module: data_mem_access

---
 rtl/data_mem_access_if.sv | 30 +++
 rtl/data_mem_access.sv | 95 +++++++++
 tb/tb_data_mem_access.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_access_if.sv
// rtl/data_mem_access_if.sv - pipeline request/response and data-memory signal bundle.
interface data_mem_access_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        busy;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_MemWrite;
  logic        mem_MemRead;
  logic        mem_distinct;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error, busy,
           mem_address, mem_write_data, mem_MemWrite, mem_MemRead, mem_distinct
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error, busy,
           mem_address, mem_write_data, mem_MemWrite, mem_MemRead, mem_distinct
  );
endinterface

// File: rtl/data_mem_access.sv
// rtl/data_mem_access.sv - single-request data memory access FSM with range check.
// Define DMEM_OUT_REG_EN when the memory has an output register (adds WAIT2 to loads).
module data_mem_access #(
  parameter int MEM_ADDR_BITS = 17
) (
  input logic              CLK,
  input logic              reset,
  data_mem_access_if.slave bus
);

`ifdef DMEM_OUT_REG_EN
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WAIT2, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
`endif

  state_t      state_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        mem_rd_q;
  logic        mem_wr_q;
  logic        range_err_d;

  assign range_err_d = (bus.req_addr >> MEM_ADDR_BITS) != 32'd0;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            write_q <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            err_q   <= range_err_d;
            // Out-of-range requests skip the memory entirely and answer next cycle.
            if (range_err_d) begin
              rdata_q <= '0;
              state_q <= S_DONE;
            end else begin
              mem_rd_q <= ~bus.req_write;
              mem_wr_q <= bus.req_write;
              state_q  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          state_q  <= write_q ? S_DONE : S_WAIT;
        end
`ifdef DMEM_OUT_REG_EN
        S_WAIT: state_q <= S_WAIT2;
        S_WAIT2: begin
          rdata_q <= bus.mem_read_data;
          state_q <= S_DONE;
        end
`else
        S_WAIT: begin
          rdata_q <= bus.mem_read_data;
          state_q <= S_DONE;
        end
`endif
        S_DONE: begin
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready      = (state_q == S_IDLE);
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.resp_valid     = (state_q == S_DONE);
  assign bus.resp_error     = (state_q == S_DONE) && err_q;
  assign bus.resp_rdata     = rdata_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.mem_MemRead    = mem_rd_q;
  assign bus.mem_MemWrite   = mem_wr_q;
  assign bus.mem_distinct   = mem_rd_q | mem_wr_q;

endmodule

// File: tb/tb_data_mem_access.sv
// tb/tb_data_mem_access.sv - directed and randomized checks against a behavioural memory model.
module tb_data_mem_access;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

`ifdef DMEM_OUT_REG_EN
  localparam int LOAD_LAT = 4;
`else
  localparam int LOAD_LAT = 3;
`endif
  localparam logic [31:0] LIMIT = 32'h0002_0000;

  data_mem_access_if bus ();

  data_mem_access #(.MEM_ADDR_BITS(17)) dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents before any store: a fixed scramble of the address.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  // Data memory device: synchronous read, optional extra output register.
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] rd_raw;
  logic [31:0] rd_out;
  always @(posedge clk) begin
    if (bus.mem_distinct && bus.mem_MemWrite) dev_mem[bus.mem_address] = bus.mem_write_data;
    if (bus.mem_distinct && bus.mem_MemRead)
      rd_raw <= dev_mem.exists(bus.mem_address) ? dev_mem[bus.mem_address] : dflt(bus.mem_address);
    rd_out <= rd_raw;
  end
`ifdef DMEM_OUT_REG_EN
  assign bus.mem_read_data = rd_out;
`else
  assign bus.mem_read_data = rd_raw;
`endif

  // Reference model: what a load should return and what resp_rdata currently holds.
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] exp_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) chk("strobe_exclusive", 32'(bus.mem_MemRead && bus.mem_MemWrite), 32'd0);
  end

  // One request: start at posedge+1 with DUT idle; end at posedge+1 of its response cycle.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    logic err;
    int   exp_k;
    err   = (addr >= LIMIT);
    exp_k = err ? 1 : (wr ? 2 : LOAD_LAT);
    chk("ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    for (int k = 1; k <= exp_k; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      chk("mem_write", 32'(bus.mem_MemWrite), 32'(k == 1 && !err && wr));
      chk("mem_read", 32'(bus.mem_MemRead), 32'(k == 1 && !err && !wr));
      chk("mem_distinct", 32'(bus.mem_distinct), 32'(k == 1 && !err));
      chk("resp_valid", 32'(bus.resp_valid), 32'(k == exp_k));
      chk("ready_busy", 32'(bus.req_ready), 32'd0);
      if (k == 1 && !err) begin
        chk("mem_address", bus.mem_address, addr);
        if (wr) chk("mem_wdata", bus.mem_write_data, wdata);
      end
    end
    if (err) exp_rdata = 32'd0;
    else if (wr) ref_mem[addr] = wdata;
    else exp_rdata = ref_mem.exists(addr) ? ref_mem[addr] : dflt(addr);
    chk("resp_error", 32'(bus.resp_error), 32'(err));
    chk("resp_rdata", bus.resp_rdata, exp_rdata);
    @(posedge clk); #1;
    chk("resp_done", 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_resp_error"}, 32'(bus.resp_error), 32'd0);
    chk({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
    chk({tag, "_strobes"}, {29'd0, bus.mem_MemRead, bus.mem_MemWrite, bus.mem_distinct}, 32'd0);
    chk({tag, "_mem_address"}, bus.mem_address, 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_write_data, 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] bb_addr [3];
    int          hs_cyc [$];
    logic [31:0] resp_q [$];
    int          nhs;
    logic        wr;
    logic [31:0] addr;
    int          sel;

    checks = 0;
    errors = 0;
    exp_rdata = 32'd0;
    reset = 1'b1;
    bus.req_valid = 1'b1;   // handshake attempt during reset must be ignored
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h40;
    bus.req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    bus.req_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    do_req(1'b0, 32'h0000_0010, 32'h0);
    chk("load_deadbeef", bus.resp_rdata, 32'hDEAD_BEEF);
    do_req(1'b0, 32'h0002_0000, 32'h0);
    do_req(1'b0, 32'h0001_FFFF, 32'h0);
    do_req(1'b1, 32'h0001_FFFF, 32'h0BAD_F00D);
    do_req(1'b0, 32'h0001_FFFF, 32'h0);
    do_req(1'b1, 32'hFFFF_FFFF, 32'h1111_1111);

    // Back-to-back loads with req_valid held high.
    bb_addr[0] = 32'h10; bb_addr[1] = 32'h1FFFF; bb_addr[2] = 32'h24;
    nhs = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (bus.resp_valid) resp_q.push_back(bus.resp_rdata);
      if (nhs < 3) begin
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = bb_addr[nhs];
        if (bus.req_ready) begin
          hs_cyc.push_back(cyc);
          nhs++;
        end
      end else bus.req_valid = 1'b0;
    end
    chk("bb_handshakes", 32'(hs_cyc.size()), 32'd3);
    chk("bb_responses", 32'(resp_q.size()), 32'd3);
    if (hs_cyc.size() == 3) begin
      chk("bb_gap0", 32'(hs_cyc[1] - hs_cyc[0]), 32'(LOAD_LAT + 1));
      chk("bb_gap1", 32'(hs_cyc[2] - hs_cyc[1]), 32'(LOAD_LAT + 1));
    end
    for (int i = 0; i < 3 && i < resp_q.size(); i++)
      chk("bb_rdata", resp_q[i], ref_mem.exists(bb_addr[i]) ? ref_mem[bb_addr[i]] : dflt(bb_addr[i]));
    exp_rdata = ref_mem.exists(bb_addr[2]) ? ref_mem[bb_addr[2]] : dflt(bb_addr[2]);
    @(posedge clk); #1;

    // Reset during WAIT of a load.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h30;
    @(posedge clk); #1;          // T+1: ISSUE
    bus.req_valid = 1'b0;
    @(posedge clk); #1;          // T+2: WAIT
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("abort");
    reset = 1'b0;
    exp_rdata = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_no_resp", 32'(bus.resp_valid), 32'd0);
      chk("abort_no_strobe", 32'(bus.mem_distinct), 32'd0);
    end
    do_req(1'b1, 32'h30, 32'hCAFE_0042);
    do_req(1'b0, 32'h30, 32'h0);

    // Random mix.
    for (int n = 0; n < 1000; n++) begin
      wr  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 15);
      if (sel == 0) addr = $urandom | (32'h1 << $urandom_range(17, 31));
      else if (sel == 1) addr = LIMIT - 32'd1;
      else addr = 32'($urandom_range(0, 31));
      do_req(wr, addr, $urandom);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
